internal_data_check: RTL and testbench
======================================

# internal_data_check

Serial pattern checker that consumes the single-bit test stream produced by the internal data generator, either looped back directly or returned through the RF/IO path. It samples the stream on rising edges of the selected data clock and self-synchronises to the pattern chosen by DAT_PAT (all-zeros, all-ones, PRBS15 or PRBS17). It then reports lock, bit count, error count and loss-of-sync events to the register bank for BER measurement.

## Interface
- LOCK_LEN, 32: consecutive correct bits required in HUNT to declare lock.
- WIN_LEN, 64: length of the loss-of-lock observation window, in sampled bits.
- LOSS_THR, 8: error count within one window that drops lock.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- data_clock  in  1  selected data clock, the same net that drives the generator; synchronous to clk.
- DAT_PAT  in  4  expected pattern: 0 all-zeros; 1 all-ones; 2 and others PRBS15; 3 PRBS17.
- rx_data  in  1  received serial data.
- clear  in  1  single-cycle pulse that zeroes bit_cnt, err_cnt and loss_cnt.
- locked  out  1  checker is synchronised.
- err_pulse  out  1  one-clk pulse for each errored bit while locked.
- bit_cnt  out  32  bits checked while locked; saturating.
- err_cnt  out  32  errored bits while locked; saturating.
- loss_cnt  out  8  LOCKED-to-HUNT transitions; saturating.

## Operation
- Sample strobe: data_clock_d is data_clock registered on clk, reset to 0. The strobe is `data_clock & ~data_clock_d`. rx_data is sampled in the strobe cycle, which captures the bit held stable for the preceding data_clock period. All state changes occur only in strobe cycles, except reset, clear and a DAT_PAT change.
- History: a 17-bit shift register. hist[0] holds the newest bit and hist[16] the oldest.
- Expected bit:
  - DAT_PAT 0 → 0.
  - DAT_PAT 1 → 1.
  - DAT_PAT 3 → hist[16]^hist[13], i.e. x[m] = x[m-17] ^ x[m-14].
  - Any other value → hist[14]^hist[13], i.e. x[m] = x[m-15] ^ x[m-14].
- Order N is 0 for patterns 0/1, 17 for pattern 3, and 15 otherwise.
- States: HUNT (reset state) and LOCKED.
- HUNT:
  - Shift rx_data into hist on every strobe, and increment fill_cnt (saturating at 17).
  - Once fill_cnt ≥ N, compare rx_data with the expected bit. A match increments match_cnt; a mismatch zeroes it.
  - When match_cnt reaches LOCK_LEN, go to LOCKED and zero the window counters.
  - No counting in this state.
- LOCKED:
  - Shift the expected bit, not rx_data, into hist. The reference free-runs, so one line error counts exactly once.
  - On each strobe, increment bit_cnt.
  - On a mismatch, increment err_cnt and win_err and pulse err_pulse.
  - After every WIN_LEN strobes, zero win_bits and win_err.
  - If win_err reaches LOSS_THR, go to HUNT, zero fill_cnt and match_cnt, and increment loss_cnt.
- A DAT_PAT change (compared against a registered copy) forces HUNT and zeroes fill_cnt and match_cnt. The counters are held. No loss_cnt increment.
- clear has priority over a coincident increment: the counter is 0 after that cycle.
- All counters saturate at all-ones and never wrap.

## Timing
- Reset: locked=0, err_pulse=0, bit_cnt=0, err_cnt=0, loss_cnt=0, hist=0, state HUNT.
- All outputs are registered. Each output updates on the clk edge that ends the strobe cycle; latency from the strobe cycle is 1 clk.
- Lock time for a clean PRBS17 stream is N+LOCK_LEN = 49 strobes; locked rises 1 clk after the 49th strobe cycle. PRBS15 takes 47 strobes; fixed patterns take 32.
- Minimum data_clock period is 2 clk, which gives one strobe per period.
- Reset asserted mid-operation takes effect on the next clk edge, regardless of strobe.

## Test plan
- Generator looped back, DAT_PAT=3, 1000 strobes → locked rises after strobe 49; bit_cnt=951; err_cnt=0; loss_cnt=0.
- DAT_PAT=2 loopback, locked, invert rx_data on one strobe → err_cnt=1, exactly one err_pulse, locked stays 1.
- DAT_PAT=0 with rx_data stuck at 1 for 500 strobes → locked stays 0; all counters remain 0.
- Locked on PRBS17, then force 8 errors within 64 strobes → locked falls; loss_cnt=1; after the stream is restored, relock in 49 strobes.
- clear pulsed in the same cycle as an errored strobe → err_cnt=0 and bit_cnt=0 on the next cycle; counting resumes from the following strobe.
- DAT_PAT switched from 3 to 2 while locked → locked=0 next clk; loss_cnt unchanged; relock after 47 clean strobes.

Source files
------------

// File: rtl/internal_data_check.sv
// Serial pattern checker: self-synchronises to a fixed or PRBS15/PRBS17 stream sampled on
// data_clock rising edges, then counts checked bits, errored bits and loss-of-lock events.
module internal_data_check #(
    parameter int unsigned LOCK_LEN = 32,
    parameter int unsigned WIN_LEN  = 64,
    parameter int unsigned LOSS_THR = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_clock,
    input  logic [3:0]  DAT_PAT,
    input  logic        rx_data,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [31:0] bit_cnt,
    output logic [31:0] err_cnt,
    output logic [7:0]  loss_cnt
);

    localparam int unsigned MW = $clog2(LOCK_LEN + 1);
    localparam int unsigned WW = $clog2(WIN_LEN + 1);
    localparam int unsigned EW = $clog2(LOSS_THR + 1);

    localparam logic [MW-1:0] LockLenM1 = MW'(LOCK_LEN - 1);
    localparam logic [WW-1:0] WinLenM1  = WW'(WIN_LEN - 1);
    localparam logic [EW-1:0] LossThrM1 = EW'(LOSS_THR - 1);

    typedef enum logic [0:0] {StHunt, StLocked} state_e;

    state_e        state;
    logic          data_clock_d;
    logic [3:0]    pat_q;
    logic [16:0]   hist;
    logic [4:0]    fill_cnt;
    logic [MW-1:0] match_cnt;
    logic [WW-1:0] win_bits;
    logic [EW-1:0] win_err;

    logic       strobe;
    logic       pat_change;
    logic       exp_bit;
    logic       mismatch;
    logic [4:0] order;
    logic       bit_inc;
    logic       err_inc;
    logic       loss_inc;

    assign strobe     = data_clock & ~data_clock_d;
    assign pat_change = (DAT_PAT != pat_q);
    assign mismatch   = (rx_data != exp_bit);

    always_comb begin
        exp_bit = 1'b0;
        order   = 5'd15;
        case (DAT_PAT)
            4'd0: begin
                exp_bit = 1'b0;
                order   = 5'd0;
            end
            4'd1: begin
                exp_bit = 1'b1;
                order   = 5'd0;
            end
            4'd3: begin
                exp_bit = hist[16] ^ hist[13];
                order   = 5'd17;
            end
            default: begin
                exp_bit = hist[14] ^ hist[13];
                order   = 5'd15;
            end
        endcase
    end

    always_comb begin
        bit_inc  = 1'b0;
        err_inc  = 1'b0;
        loss_inc = 1'b0;
        if (strobe && !pat_change && state == StLocked) begin
            bit_inc  = 1'b1;
            err_inc  = mismatch;
            loss_inc = mismatch && (win_err == LossThrM1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StHunt;
            data_clock_d <= 1'b0;
            pat_q        <= DAT_PAT;
            hist         <= '0;
            fill_cnt     <= '0;
            match_cnt    <= '0;
            win_bits     <= '0;
            win_err      <= '0;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
        end else begin
            data_clock_d <= data_clock;
            pat_q        <= DAT_PAT;
            err_pulse    <= 1'b0;
            if (pat_change) begin
                // Pattern change restarts acquisition without counting a loss.
                state     <= StHunt;
                locked    <= 1'b0;
                fill_cnt  <= '0;
                match_cnt <= '0;
            end else if (strobe) begin
                unique case (state)
                    StHunt: begin
                        hist <= {hist[15:0], rx_data};
                        if (fill_cnt != 5'd17) begin
                            fill_cnt <= fill_cnt + 5'd1;
                        end
                        if (fill_cnt >= order) begin
                            if (mismatch) begin
                                match_cnt <= '0;
                            end else if (match_cnt == LockLenM1) begin
                                state     <= StLocked;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                                win_bits  <= '0;
                                win_err   <= '0;
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end
                    end
                    StLocked: begin
                        // Reference free-runs on its own prediction, so a line error counts once.
                        hist <= {hist[15:0], exp_bit};
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                        end
                        if (loss_inc) begin
                            state     <= StHunt;
                            locked    <= 1'b0;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                            win_bits  <= '0;
                            win_err   <= '0;
                        end else if (win_bits == WinLenM1) begin
                            win_bits <= '0;
                            win_err  <= '0;
                        end else begin
                            win_bits <= win_bits + WW'(1);
                            win_err  <= win_err + EW'(mismatch);
                        end
                    end
                    default: begin
                        state <= StHunt;
                    end
                endcase
            end
        end
    end

    // Statistics counters: clear wins over a coincident increment; all saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            err_cnt  <= '0;
            loss_cnt <= '0;
        end else if (clear) begin
            bit_cnt  <= '0;
            err_cnt  <= '0;
            loss_cnt <= '0;
        end else begin
            if (bit_inc && bit_cnt != '1) begin
                bit_cnt <= bit_cnt + 32'd1;
            end
            if (err_inc && err_cnt != '1) begin
                err_cnt <= err_cnt + 32'd1;
            end
            if (loss_inc && loss_cnt != '1) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_internal_data_check.sv
// Directed bench for internal_data_check: per-strobe expectations go through a scoreboard queue.
module tb_internal_data_check;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_clock;
    logic [3:0]  dat_pat;
    logic        rx_data;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [31:0] bit_cnt;
    logic [31:0] err_cnt;
    logic [7:0]  loss_cnt;

    internal_data_check dut (
        .clk        (clk),
        .rst        (rst),
        .data_clock (data_clock),
        .DAT_PAT    (dat_pat),
        .rx_data    (rx_data),
        .clear      (clear),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .bit_cnt    (bit_cnt),
        .err_cnt    (err_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic lk;
        logic ep;
    } exp_t;

    exp_t        sb[$];
    logic        gen[$];
    logic [16:0] seed = 17'h1ACE5;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference generator written straight from the recurrences x[m]=x[m-17]^x[m-14] and
    // x[m]=x[m-15]^x[m-14], seeded from a fixed non-zero word.
    task automatic gen_bit(input int pat, output logic b);
        int m;
        m = gen.size();
        if (pat == 0) b = 1'b0;
        else if (pat == 1) b = 1'b1;
        else if (pat == 3) b = (m < 17) ? seed[m] : (gen[m-17] ^ gen[m-14]);
        else b = (m < 15) ? seed[m] : (gen[m-15] ^ gen[m-14]);
        gen.push_back(b);
    endtask

    // One data_clock period of 2 clk; the strobe cycle carries the bit.
    task automatic send(input logic b, input logic clr, input logic elk, input logic eep,
                        input string tag);
        exp_t e;
        @(posedge clk); #1;
        data_clock = 1'b1;
        rx_data    = b;
        clear      = clr;
        sb.push_back('{lk: elk, ep: eep});
        @(posedge clk); #1;
        data_clock = 1'b0;
        clear      = 1'b0;
        e = sb.pop_front();
        chk({tag, " locked"}, {31'd0, locked}, {31'd0, e.lk});
        chk({tag, " err_pulse"}, {31'd0, err_pulse}, {31'd0, e.ep});
    endtask

    task automatic set_pat(input logic [3:0] p);
        @(posedge clk); #1;
        dat_pat = p;
        @(posedge clk); #1;
        chk("pat_change locked", {31'd0, locked}, 32'd0);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear bit_cnt", bit_cnt, 32'd0);
        chk("clear err_cnt", err_cnt, 32'd0);
        chk("clear loss_cnt", {24'd0, loss_cnt}, 32'd0);
    endtask

    initial begin
        logic b;
        rst        = 1'b1;
        data_clock = 1'b0;
        dat_pat    = 4'd3;
        rx_data    = 1'b0;
        clear      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset locked", {31'd0, locked}, 32'd0);
        chk("reset err_pulse", {31'd0, err_pulse}, 32'd0);
        chk("reset bit_cnt", bit_cnt, 32'd0);
        chk("reset err_cnt", err_cnt, 32'd0);
        chk("reset loss_cnt", {24'd0, loss_cnt}, 32'd0);

        // PRBS17 loopback: lock on strobe 49, then 951 counted bits.
        for (int i = 1; i <= 1000; i++) begin
            gen_bit(3, b);
            send(b, 1'b0, (i >= 49), 1'b0, "prbs17_lock");
        end
        chk("prbs17 bit_cnt", bit_cnt, 32'd951);
        chk("prbs17 err_cnt", err_cnt, 32'd0);
        chk("prbs17 loss_cnt", {24'd0, loss_cnt}, 32'd0);

        // Burst of 8 errors inside one window drops lock.
        for (int i = 0; i < 20; i++) begin
            gen_bit(3, b);
            send(b, 1'b0, 1'b1, 1'b0, "pre_burst");
        end
        for (int i = 1; i <= 8; i++) begin
            gen_bit(3, b);
            send(~b, 1'b0, (i < 8), 1'b1, "burst");
        end
        chk("loss loss_cnt", {24'd0, loss_cnt}, 32'd1);
        chk("loss err_cnt", err_cnt, 32'd8);
        chk("loss bit_cnt", bit_cnt, 32'd979);
        for (int i = 1; i <= 49; i++) begin
            gen_bit(3, b);
            send(b, 1'b0, (i >= 49), 1'b0, "relock17");
        end
        chk("relock bit_cnt held", bit_cnt, 32'd979);

        // clear coincident with an errored strobe.
        gen_bit(3, b);
        send(~b, 1'b1, 1'b1, 1'b1, "clear_err");
        chk("clear_err bit_cnt", bit_cnt, 32'd0);
        chk("clear_err err_cnt", err_cnt, 32'd0);
        chk("clear_err loss_cnt", {24'd0, loss_cnt}, 32'd0);
        gen_bit(3, b);
        send(b, 1'b0, 1'b1, 1'b0, "after_clear");
        chk("after_clear bit_cnt", bit_cnt, 32'd1);
        gen_bit(3, b);
        send(~b, 1'b0, 1'b1, 1'b1, "after_clear_err");
        chk("after_clear_err err_cnt", err_cnt, 32'd1);
        chk("after_clear_err bit_cnt", bit_cnt, 32'd2);

        // Switch to PRBS15 while locked: immediate unlock, counters held, relock in 47.
        set_pat(4'd2);
        chk("switch loss_cnt", {24'd0, loss_cnt}, 32'd0);
        chk("switch bit_cnt", bit_cnt, 32'd2);
        chk("switch err_cnt", err_cnt, 32'd1);
        gen.delete();
        for (int i = 1; i <= 47; i++) begin
            gen_bit(2, b);
            send(b, 1'b0, (i >= 47), 1'b0, "prbs15_lock");
        end
        chk("prbs15 bit_cnt", bit_cnt, 32'd2);

        // Single line error on PRBS15 counts exactly once.
        pulse_clear();
        for (int i = 0; i < 30; i++) begin
            gen_bit(2, b);
            send(b, 1'b0, 1'b1, 1'b0, "prbs15_clean");
        end
        gen_bit(2, b);
        send(~b, 1'b0, 1'b1, 1'b1, "prbs15_err");
        for (int i = 0; i < 10; i++) begin
            gen_bit(2, b);
            send(b, 1'b0, 1'b1, 1'b0, "prbs15_post");
        end
        chk("prbs15 single err_cnt", err_cnt, 32'd1);
        chk("prbs15 single bit_cnt", bit_cnt, 32'd41);
        chk("prbs15 single loss_cnt", {24'd0, loss_cnt}, 32'd0);

        // All-zeros expected, line stuck at 1: never locks, nothing counted.
        set_pat(4'd0);
        pulse_clear();
        for (int i = 0; i < 500; i++) begin
            send(1'b1, 1'b0, 1'b0, 1'b0, "stuck1");
        end
        chk("stuck1 bit_cnt", bit_cnt, 32'd0);
        chk("stuck1 err_cnt", err_cnt, 32'd0);
        chk("stuck1 loss_cnt", {24'd0, loss_cnt}, 32'd0);

        // All-ones pattern locks after 32 strobes.
        set_pat(4'd1);
        for (int i = 1; i <= 40; i++) begin
            send(1'b1, 1'b0, (i >= 32), 1'b0, "ones");
        end
        chk("ones bit_cnt", bit_cnt, 32'd8);
        chk("ones err_cnt", err_cnt, 32'd0);

        // Reset mid-operation takes effect on the next edge.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset locked", {31'd0, locked}, 32'd0);
        chk("midreset bit_cnt", bit_cnt, 32'd0);

        chk("scoreboard drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
